// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sprite_fetch_arbiter                                             |
// | Purpose : Round-robin burst arbiter sharing a sprite index ROM and a       |
// |           palette ROM between two renderers; emits tagged RGB pixels.      |
// | Option  : `define SPRITE_TRANSPARENCY_EN flags pixels whose index was 0.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sprite_fetch_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int IDX_W   = 4,
    parameter int COLOR_W = 24,
    parameter int LEN_W   = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [1:0]         req,
    input  logic [ADDR_W-1:0]  base0,
    input  logic [ADDR_W-1:0]  base1,
    input  logic [LEN_W-1:0]   len0,
    input  logic [LEN_W-1:0]   len1,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_data,
    output logic [IDX_W-1:0]   pal_addr,
    input  logic [COLOR_W-1:0] pal_data,
    output logic               pix_valid,
    output logic               pix_owner,
    output logic [LEN_W-1:0]   pix_offset,
    output logic               pix_last,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_transparent
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              w_at_end;
    logic              w_take;
    logic              w_win;

    // cnt_q is the offset currently presented on rom_addr
    assign w_at_end = (cnt_q == len_q);
    assign w_win    = (req == 2'b11) ? ~ptr_q : req[1];
    assign w_take   = (|req) && !Reset && ((state_q == S_IDLE) || w_at_end);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_take) state_d = S_BURST;
            S_BURST: if (w_at_end && !w_take) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (w_take) begin
            gnt[w_win] = 1'b1;
        end
        busy = (state_q == S_BURST);
    end

    // A new burst loads its first address at the grant edge so it appears with no bubble
    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        if (w_take) begin
            ptr_d      = w_win;
            owner_d    = w_win;
            base_d     = w_win ? base1 : base0;
            len_d      = w_win ? len1 : len0;
            cnt_d      = '0;
            rom_addr_d = base_d;
        end else if (busy && !w_at_end) begin
            cnt_d      = cnt_q + LEN_W'(1);
            rom_addr_d = base_q + ADDR_W'(cnt_d);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q      <= 1'b1;
            owner_q    <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign pal_addr = rom_data;

    logic              s2_valid_q, s2_owner_q, s2_last_q;
    logic [LEN_W-1:0]  s2_cnt_q;
    logic              s3_valid_q, s3_owner_q, s3_last_q;
    logic [LEN_W-1:0]  s3_cnt_q;
    logic              pix_valid_q, pix_owner_q, pix_last_q;
    logic [LEN_W-1:0]  pix_offset_q;
    logic [COLOR_W-1:0] pix_color_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s2_valid_q   <= 1'b0;
            s2_owner_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_cnt_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_owner_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            s3_cnt_q     <= '0;
            pix_valid_q  <= 1'b0;
            pix_owner_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            pix_offset_q <= '0;
            pix_color_q  <= '0;
        end else begin
            s2_valid_q   <= busy;
            s2_owner_q   <= owner_q;
            s2_last_q    <= w_at_end;
            s2_cnt_q     <= cnt_q;
            s3_valid_q   <= s2_valid_q;
            s3_owner_q   <= s2_owner_q;
            s3_last_q    <= s2_last_q;
            s3_cnt_q     <= s2_cnt_q;
            pix_valid_q  <= s3_valid_q;
            if (s3_valid_q) begin
                pix_owner_q  <= s3_owner_q;
                pix_last_q   <= s3_last_q;
                pix_offset_q <= s3_cnt_q;
                pix_color_q  <= pal_data;
            end
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_owner  = pix_owner_q;
    assign pix_last   = pix_last_q;
    assign pix_offset = pix_offset_q;
    assign pix_color  = pix_color_q;

`ifdef SPRITE_TRANSPARENCY_EN
    logic s3_idx_zero_q;
    logic pix_transparent_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s3_idx_zero_q     <= 1'b0;
            pix_transparent_q <= 1'b0;
        end else begin
            s3_idx_zero_q <= (rom_data == '0);
            if (s3_valid_q) begin
                pix_transparent_q <= s3_idx_zero_q;
            end
        end
    end

    assign pix_transparent = pix_transparent_q;
`else
    assign pix_transparent = 1'b0;
`endif

endmodule
`default_nettype wire
